// File: rtl/y86_pkg.sv
// Y86-64 shared definitions: instruction codes, status codes and
// the fetch halt-state encoding.
package y86_pkg;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  localparam logic [3:0] RNONE = 4'hF;

  typedef enum logic {
    S_RUN,
    S_HALTED
  } halt_state_e;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory port of the fetch stage: the fetch PC goes out,
// a 10-byte little-endian window and an address error come back.
interface fetch_stage_if #(
  parameter int unsigned PC_W = 64
);
  logic [PC_W-1:0] addr;
  logic [79:0]     bytes;
  logic            error;

  modport master (output addr, input bytes, error);
  modport slave  (input addr, output bytes, error);
endinterface

// File: rtl/fetch_align.sv
// Splits the instruction window into fields and computes the
// constant word and the sequential next PC.
module fetch_align
  import y86_pkg::*;
#(
  parameter int unsigned PC_W = 64
) (
  input  logic [PC_W-1:0] pc,
  input  logic [79:0]     bytes,
  input  logic            err,
  output logic [3:0]      icode,
  output logic [3:0]      ifun,
  output logic [3:0]      ra,
  output logic [3:0]      rb,
  output logic [63:0]     valc,
  output logic [PC_W-1:0] valp
);

  logic need_regids;
  logic need_valc;

  always_comb begin
    icode       = err ? INOP : bytes[7:4];
    ifun        = err ? 4'h0 : bytes[3:0];
    need_regids = 1'b0;
    need_valc   = 1'b0;
    case (icode)
      IRRMOVQ, IOPQ, IPUSHQ, IPOPQ: need_regids = 1'b1;
      IIRMOVQ, IRMMOVQ, IMRMOVQ: begin
        need_regids = 1'b1;
        need_valc   = 1'b1;
      end
      IJXX, ICALL: need_valc = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    ra   = need_regids ? bytes[15:12] : RNONE;
    rb   = need_regids ? bytes[11:8]  : RNONE;
    valc = '0;
    if (need_valc)
      valc = need_regids ? bytes[79:16] : bytes[71:8];
    // Wraps modulo 2^PC_W by construction.
    valp = pc + PC_W'(1) + PC_W'(need_regids)
         + (need_valc ? PC_W'(8) : '0);
  end

endmodule

// File: rtl/fetch_stage.sv
// Y86-64 fetch stage: PC select, F register, field extraction and a
// sticky halt FSM that freezes fetch after HLT/ADR/INS.
module fetch_stage
  import y86_pkg::*;
#(
  parameter int unsigned    PC_W     = 64,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            F_stall,
  input  logic [3:0]      M_icode,
  input  logic            M_Cnd,
  input  logic [PC_W-1:0] M_valA,
  input  logic [3:0]      W_icode,
  input  logic [PC_W-1:0] W_valM,
  fetch_stage_if.master   imem,
  output logic [2:0]      f_stat,
  output logic [3:0]      f_icode,
  output logic [3:0]      f_ifun,
  output logic [3:0]      f_rA,
  output logic [3:0]      f_rB,
  output logic [63:0]     f_valC,
  output logic [PC_W-1:0] f_valP,
  output logic [PC_W-1:0] f_pred_PC,
  output logic            f_halted
);

  halt_state_e     state_q, state_d;
  logic [2:0]      stat_q, stat_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] f_pc;

  logic mispredict, ret_sel, redirect, frozen;

  logic [3:0]      a_icode, a_ifun, a_ra, a_rb;
  logic [63:0]     a_valc;
  logic [PC_W-1:0] a_valp;
  logic [2:0]      a_stat;

  assign mispredict = (M_icode == IJXX) && !M_Cnd;
  assign ret_sel    = (W_icode == IRET);
  assign redirect   = mispredict || ret_sel;
  // A redirect pulls the stage out of HALTED in the same cycle.
  assign frozen     = (state_q == S_HALTED) && !redirect;

  always_comb begin
    if (mispredict)   f_pc = M_valA;
    else if (ret_sel) f_pc = W_valM;
    else              f_pc = pc_q;
  end

  assign imem.addr = f_pc;

  fetch_align #(.PC_W(PC_W)) u_align (
    .pc    (f_pc),
    .bytes (imem.bytes),
    .err   (imem.error),
    .icode (a_icode),
    .ifun  (a_ifun),
    .ra    (a_ra),
    .rb    (a_rb),
    .valc  (a_valc),
    .valp  (a_valp)
  );

  always_comb begin
    if (imem.error)              a_stat = STAT_ADR;
    else if (a_icode > IPOPQ)    a_stat = STAT_INS;
    else if (a_icode == IHALT)   a_stat = STAT_HLT;
    else                         a_stat = STAT_AOK;
  end

  always_comb begin
    f_icode   = a_icode;
    f_ifun    = a_ifun;
    f_rA      = a_ra;
    f_rB      = a_rb;
    f_valC    = a_valc;
    f_valP    = a_valp;
    f_stat    = a_stat;
    f_pred_PC = a_valp;
    if (a_icode == IJXX || a_icode == ICALL)
      f_pred_PC = PC_W'(a_valc);
    if (frozen) begin
      f_icode   = INOP;
      f_ifun    = 4'h0;
      f_rA      = RNONE;
      f_rB      = RNONE;
      f_valC    = '0;
      f_valP    = f_pc;
      f_pred_PC = f_pc;
      f_stat    = stat_q;
    end
  end

  always_comb begin
    pc_d    = pc_q;
    state_d = state_q;
    stat_d  = stat_q;
    if (!F_stall) begin
      if (!frozen)
        pc_d = f_pred_PC;
      if (redirect) begin
        state_d = S_RUN;
        stat_d  = STAT_AOK;
      end else if (state_q == S_RUN && a_stat != STAT_AOK) begin
        state_d = S_HALTED;
        stat_d  = a_stat;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      state_q <= S_RUN;
      stat_q  <= STAT_AOK;
    end else begin
      pc_q    <= pc_d;
      state_q <= state_d;
      stat_q  <= stat_d;
    end
  end

  assign f_halted = (state_q == S_HALTED);

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: expected observations are queued
// as stimulus is applied and compared when the outputs settle.
module tb_fetch_stage;
  import y86_pkg::*;

  typedef struct packed {
    logic [63:0] addr;
    logic [2:0]  stat;
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [63:0] valc;
    logic [63:0] valp;
    logic [63:0] pred;
    logic        halted;
  } obs_t;

  typedef struct {
    string name;
    obs_t  exp;
    obs_t  msk;
  } sb_t;

  localparam logic [79:0] B_IRMOV = {64'd10, 8'hF2, 8'h30};
  localparam logic [79:0] B_JMP20 = {8'h00, 64'h20, 8'h70};
  localparam logic [79:0] B_JXX40 = {8'h00, 64'h40, 8'h70};
  localparam logic [79:0] B_NOP   = {72'h0, 8'h10};
  localparam logic [79:0] B_HALT  = {72'h0, 8'h00};
  localparam logic [79:0] B_BAD   = {72'h0, 8'hC0};
  localparam logic [79:0] B_PUSH  = {64'hFFFF_FFFF_FFFF_FFFF, 8'h3F, 8'hA0};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        F_stall = 1'b0;
  logic [3:0]  M_icode = INOP;
  logic        M_Cnd = 1'b0;
  logic [63:0] M_valA = '0;
  logic [3:0]  W_icode = INOP;
  logic [63:0] W_valM = '0;
  logic [2:0]  f_stat;
  logic [3:0]  f_icode, f_ifun, f_rA, f_rB;
  logic [63:0] f_valC, f_valP, f_pred_PC;
  logic        f_halted;

  sb_t sb[$];
  int  errs = 0;
  int  checks = 0;
  obs_t ALL;
  obs_t M_AH;

  fetch_stage_if #(.PC_W(64)) imem ();

  fetch_stage #(.PC_W(64), .RESET_PC(64'd0)) dut (
    .clk       (clk),
    .rst       (rst),
    .F_stall   (F_stall),
    .M_icode   (M_icode),
    .M_Cnd     (M_Cnd),
    .M_valA    (M_valA),
    .W_icode   (W_icode),
    .W_valM    (W_valM),
    .imem      (imem),
    .f_stat    (f_stat),
    .f_icode   (f_icode),
    .f_ifun    (f_ifun),
    .f_rA      (f_rA),
    .f_rB      (f_rB),
    .f_valC    (f_valC),
    .f_valP    (f_valP),
    .f_pred_PC (f_pred_PC),
    .f_halted  (f_halted)
  );

  always #5 clk = ~clk;

  function automatic obs_t mk(
    input logic [63:0] addr, input logic [2:0] stat,
    input logic [3:0] icode, input logic [3:0] ifun,
    input logic [3:0] ra, input logic [3:0] rb,
    input logic [63:0] valc, input logic [63:0] valp,
    input logic [63:0] pred, input logic halted);
    obs_t o;
    o = '{addr, stat, icode, ifun, ra, rb, valc, valp, pred, halted};
    return o;
  endfunction

  function automatic obs_t cur();
    obs_t o;
    o = '{imem.addr, f_stat, f_icode, f_ifun, f_rA, f_rB,
          f_valC, f_valP, f_pred_PC, f_halted};
    return o;
  endfunction

  task automatic test_reset();
    sb_t s; obs_t o;
    imem.bytes = B_IRMOV;
    imem.error = 1'b0;
    @(negedge clk);
    sb.push_back('{"reset_irmovq",
      mk(0, STAT_AOK, IIRMOVQ, 0, RNONE, 4'h2, 10, 10, 10, 0), ALL});
    #1;
    s = sb.pop_front(); o = cur(); checks++;
    if ((o & s.msk) !== (s.exp & s.msk)) begin
      errs++;
      $display("FAIL %s got=%h exp=%h", s.name, o, s.exp);
    end
    rst = 1'b0;
  endtask

  task automatic test_irmovq();
    sb_t s; obs_t o;
    @(negedge clk);
    imem.bytes = B_JMP20;
    sb.push_back('{"irmovq_loaded_pc",
      mk(10, STAT_AOK, IJXX, 0, RNONE, RNONE, 64'h20, 64'h13, 64'h20, 0),
      ALL});
    #1;
    s = sb.pop_front(); o = cur(); checks++;
    if ((o & s.msk) !== (s.exp & s.msk)) begin
      errs++;
      $display("FAIL %s got=%h exp=%h", s.name, o, s.exp);
    end
  endtask

  task automatic test_jxx();
    sb_t s; obs_t o;
    @(negedge clk);
    imem.bytes = B_JXX40;
    sb.push_back('{"jxx_pred",
      mk(64'h20, STAT_AOK, IJXX, 0, RNONE, RNONE, 64'h40, 64'h29,
         64'h40, 0), ALL});
    #1;
    s = sb.pop_front(); o = cur(); checks++;
    if ((o & s.msk) !== (s.exp & s.msk)) begin
      errs++;
      $display("FAIL %s got=%h exp=%h", s.name, o, s.exp);
    end
  endtask

  task automatic test_redirect();
    sb_t s; obs_t o;
    sb.push_back('{"mispredict_over_ret",
      mk(64'h29, STAT_AOK, INOP, 0, RNONE, RNONE, 0, 64'h2A, 64'h2A, 0),
      ALL});
    sb.push_back('{"ret_select",
      mk(64'h100, STAT_AOK, INOP, 0, RNONE, RNONE, 0, 64'h101, 64'h101, 0),
      ALL});
    sb.push_back('{"after_ret",
      mk(64'h101, STAT_AOK, INOP, 0, RNONE, RNONE, 0, 64'h102, 64'h102, 0),
      ALL});
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      imem.bytes = B_NOP;
      M_icode = (i == 0) ? IJXX : INOP;
      M_Cnd   = 1'b0;
      M_valA  = 64'h29;
      W_icode = (i < 2) ? IRET : INOP;
      W_valM  = 64'h100;
      #1;
      s = sb.pop_front(); o = cur(); checks++;
      if ((o & s.msk) !== (s.exp & s.msk)) begin
        errs++;
        $display("FAIL %s got=%h exp=%h", s.name, o, s.exp);
      end
    end
  endtask

  task automatic test_stall();
    sb_t s; obs_t o;
    @(negedge clk);
    imem.bytes = B_PUSH;
    F_stall = 1'b1;
    for (int i = 0; i < 4; i++)
      sb.push_back('{$sformatf("stall_hold_%0d", i),
        mk(64'h102, STAT_AOK, IPUSHQ, 0, 4'h3, RNONE, 0, 64'h104,
           64'h104, 0), ALL});
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      s = sb.pop_front(); o = cur(); checks++;
      if ((o & s.msk) !== (s.exp & s.msk)) begin
        errs++;
        $display("FAIL %s got=%h exp=%h", s.name, o, s.exp);
      end
    end
    F_stall = 1'b0;
  endtask

  task automatic test_halt();
    sb_t s; obs_t o;
    @(negedge clk);
    imem.bytes = B_HALT;
    sb.push_back('{"halt_fetch",
      mk(64'h104, STAT_HLT, IHALT, 0, RNONE, RNONE, 0, 64'h105,
         64'h105, 0), ALL});
    #1;
    s = sb.pop_front(); o = cur(); checks++;
    if ((o & s.msk) !== (s.exp & s.msk)) begin
      errs++;
      $display("FAIL %s got=%h exp=%h", s.name, o, s.exp);
    end
    for (int i = 0; i < 5; i++)
      sb.push_back('{$sformatf("halt_frozen_%0d", i),
        mk(64'h105, STAT_HLT, INOP, 0, RNONE, RNONE, 0, 64'h105,
           64'h105, 1), ALL});
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      imem.bytes = B_IRMOV;
      #1;
      s = sb.pop_front(); o = cur(); checks++;
      if ((o & s.msk) !== (s.exp & s.msk)) begin
        errs++;
        $display("FAIL %s got=%h exp=%h", s.name, o, s.exp);
      end
    end
    @(negedge clk);
    imem.bytes = B_NOP;
    M_icode = IJXX; M_Cnd = 1'b0; M_valA = 64'h200;
    sb.push_back('{"halt_redirect",
      mk(64'h200, 0, 0, 0, 0, 0, 0, 0, 0, 1), M_AH});
    #1;
    s = sb.pop_front(); o = cur(); checks++;
    if ((o & s.msk) !== (s.exp & s.msk)) begin
      errs++;
      $display("FAIL %s got=%h exp=%h", s.name, o, s.exp);
    end
    @(negedge clk);
    M_icode = INOP;
    sb.push_back('{"halt_recovered",
      mk(0, STAT_AOK, INOP, 0, 0, 0, 0, 0, 0, 0),
      mk(0, 3'h7, 4'hF, 0, 0, 0, 0, 0, 0, 1)});
    #1;
    s = sb.pop_front(); o = cur(); checks++;
    if ((o & s.msk) !== (s.exp & s.msk)) begin
      errs++;
      $display("FAIL %s got=%h exp=%h", s.name, o, s.exp);
    end
  endtask

  task automatic test_reset_halted();
    sb_t s; obs_t o;
    sb.push_back('{"halt_again_fetch",
      mk(0, STAT_HLT, 0, 0, 0, 0, 0, 0, 0, 0),
      mk(0, 3'h7, 0, 0, 0, 0, 0, 0, 0, 1)});
    sb.push_back('{"halted_again",
      mk(0, STAT_HLT, 0, 0, 0, 0, 0, 0, 0, 1),
      mk(0, 3'h7, 0, 0, 0, 0, 0, 0, 0, 1)});
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      imem.bytes = (i == 0) ? B_HALT : B_IRMOV;
      #1;
      s = sb.pop_front(); o = cur(); checks++;
      if ((o & s.msk) !== (s.exp & s.msk)) begin
        errs++;
        $display("FAIL %s got=%h exp=%h", s.name, o, s.exp);
      end
    end
    #1;
    rst = 1'b1;
    sb.push_back('{"reset_in_halted",
      mk(0, STAT_AOK, IIRMOVQ, 0, RNONE, 4'h2, 10, 10, 10, 0), ALL});
    #1;
    s = sb.pop_front(); o = cur(); checks++;
    if ((o & s.msk) !== (s.exp & s.msk)) begin
      errs++;
      $display("FAIL %s got=%h exp=%h", s.name, o, s.exp);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_invalid();
    sb_t s; obs_t o;
    F_stall = 1'b1;
    imem.bytes = B_BAD;
    sb.push_back('{"invalid_icode",
      mk(0, STAT_INS, 4'hC, 0, RNONE, RNONE, 0, 1, 1, 0), ALL});
    sb.push_back('{"imem_error",
      mk(0, STAT_ADR, INOP, 0, RNONE, RNONE, 0, 1, 1, 0), ALL});
    for (int i = 0; i < 2; i++) begin
      imem.error = (i == 1);
      #1;
      s = sb.pop_front(); o = cur(); checks++;
      if ((o & s.msk) !== (s.exp & s.msk)) begin
        errs++;
        $display("FAIL %s got=%h exp=%h", s.name, o, s.exp);
      end
    end
    F_stall = 1'b0;
    @(negedge clk);
    sb.push_back('{"adr_latched",
      mk(1, STAT_ADR, INOP, 0, RNONE, RNONE, 0, 1, 1, 1), ALL});
    #1;
    s = sb.pop_front(); o = cur(); checks++;
    if ((o & s.msk) !== (s.exp & s.msk)) begin
      errs++;
      $display("FAIL %s got=%h exp=%h", s.name, o, s.exp);
    end
    @(negedge clk);
    imem.error = 1'b0;
    imem.bytes = B_NOP;
    W_icode = IRET; W_valM = 64'h300;
    sb.push_back('{"halt_ret_redirect",
      mk(64'h300, 0, 0, 0, 0, 0, 0, 0, 0, 1), M_AH});
    #1;
    s = sb.pop_front(); o = cur(); checks++;
    if ((o & s.msk) !== (s.exp & s.msk)) begin
      errs++;
      $display("FAIL %s got=%h exp=%h", s.name, o, s.exp);
    end
    @(negedge clk);
    W_icode = INOP;
    sb.push_back('{"ret_recovered",
      mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0),
      mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1)});
    #1;
    s = sb.pop_front(); o = cur(); checks++;
    if ((o & s.msk) !== (s.exp & s.msk)) begin
      errs++;
      $display("FAIL %s got=%h exp=%h", s.name, o, s.exp);
    end
  endtask

  task automatic test_wrap();
    sb_t s; obs_t o;
    @(negedge clk);
    F_stall = 1'b1;
    imem.bytes = B_IRMOV;
    M_icode = IJXX; M_Cnd = 1'b0; M_valA = 64'hFFFF_FFFF_FFFF_FFFC;
    sb.push_back('{"valp_wrap",
      mk(64'hFFFF_FFFF_FFFF_FFFC, STAT_AOK, IIRMOVQ, 0, RNONE, 4'h2,
         10, 6, 6, 0), ALL});
    #1;
    s = sb.pop_front(); o = cur(); checks++;
    if ((o & s.msk) !== (s.exp & s.msk)) begin
      errs++;
      $display("FAIL %s got=%h exp=%h", s.name, o, s.exp);
    end
    M_icode = INOP;
    F_stall = 1'b0;
  endtask

  initial begin
    ALL  = '1;
    M_AH = mk('1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    test_reset();
    test_irmovq();
    test_jxx();
    test_redirect();
    test_stall();
    test_halt();
    test_reset_halted();
    test_invalid();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
